regfile_write_arbiter: RTL

//   Shares the single write port (WR/DA/D) of the 16x16 register_file between NUM_REQ

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_picker.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and helpers for the regfile write arbiter.
// Consumers import regfile_write_arbiter_pkg::*.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_REGS = 16;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Requester index `offset` places after `last` in round-robin order over n requesters.
    function automatic logic [1:0] rr_index(input logic [1:0] last, input int offset, input int n);
        int s;
        s = (int'(last) + offset) % n;
        return s[1:0];
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational round-robin picker: searches upward from the requester after last_grant.
// Produces a one-hot grant plus its encoded index.
module rr_priority_picker
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_idx
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = rr_index(last_grant, k, NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register_file write port (WR/DA/D) between NUM_REQ
// requesters; write-port outputs are registered one cycle after the transfer.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int NUM_REQ    = 2,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Freeze,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      WR,
    output logic [ADDR_W-1:0]         DA,
    output logic [DATA_W-1:0]         D,
    output logic [1:0]                grant_id,
    output logic [CNT_W-1:0]          conflict_count
);

    // Handshake: a transfer on requester i happens at a rising Clock edge when
    // req_valid[i] & req_ready[i]; requesters hold valid/addr/data stable until then.
    // req_ready is combinational and at most one bit is set.

    logic [NUM_REQ-1:0] req_eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_idx;
    logic               xfer;
    logic               drop_r0;
    logic               lose;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic [1:0]         last_grant_d, last_grant_q;
    logic               wr_d, wr_q;
    logic [ADDR_W-1:0]  da_d, da_q;
    logic [DATA_W-1:0]  d_d, d_q;
    logic [1:0]         grant_id_d, grant_id_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    assign req_eligible = Freeze ? '0 : req_valid;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (req_eligible),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer    = |gnt;
    assign drop_r0 = PROTECT_R0 && (sel_addr == '0);
    assign lose    = !Freeze && |(req_valid & ~gnt);

    // A dropped R0 write still consumes the grant, but leaves DA/D untouched.
    always_comb begin
        last_grant_d = xfer ? gnt_idx : last_grant_q;
        wr_d         = xfer && !drop_r0;
        da_d         = wr_d ? sel_addr : da_q;
        d_d          = wr_d ? sel_data : d_q;
        grant_id_d   = wr_d ? gnt_idx : grant_id_q;
        cnt_d        = cnt_q;
        if (lose && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_grant_q <= 2'(NUM_REQ - 1);
            wr_q         <= 1'b0;
            da_q         <= '0;
            d_q          <= '0;
            grant_id_q   <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            da_q         <= da_d;
            d_q          <= d_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready      = gnt;
    assign WR             = wr_q;
    assign DA             = da_q;
    assign D              = d_q;
    assign grant_id       = grant_id_q;
    assign conflict_count = cnt_q;

endmodule
